// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes from received bytes and queues
// complete {code, ext, brk} key events in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned TO_W        = 21
) (
  input  logic       clk_nexys,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] dato,
  input  logic       rd_en,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       fifo_full,
  output logic       overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXT  = 2'd1;
  localparam logic [1:0] BRK  = 2'd2;

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [1:0]      state, state_n;
  logic            ext_flag, ext_flag_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            push_c;
  logic [7:0]      push_code_c;
  logic            push_ext_c;
  logic            push_brk_c;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hE1) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Decoder state register
  always_ff @(posedge clk_nexys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ext_flag <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      ext_flag <= ext_flag_n;
      to_cnt   <= to_cnt_n;
    end
  end

  // Prefix decoding; a byte arriving on the expiry cycle is decoded normally
  always_comb begin
    state_n     = state;
    ext_flag_n  = ext_flag;
    to_cnt_n    = to_cnt;
    push_c      = 1'b0;
    push_code_c = dato;
    push_ext_c  = 1'b0;
    push_brk_c  = 1'b0;
    if (rx_done_tick) begin
      to_cnt_n = '0;
      if (is_discard(dato)) begin
        state_n    = IDLE;
        ext_flag_n = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (dato == 8'hE0) begin
              state_n    = EXT;
              ext_flag_n = 1'b1;
            end else if (dato == 8'hF0) begin
              state_n    = BRK;
              ext_flag_n = 1'b0;
            end else begin
              push_c = 1'b1;
            end
          end
          EXT: begin
            if (dato == 8'hF0) begin
              state_n = BRK;
            end else if (dato != 8'hE0) begin
              push_c     = 1'b1;
              push_ext_c = 1'b1;
              state_n    = IDLE;
              ext_flag_n = 1'b0;
            end
          end
          BRK: begin
            if (dato == 8'hE0) begin
              ext_flag_n = 1'b1;
            end else if (dato != 8'hF0) begin
              push_c     = 1'b1;
              push_ext_c = ext_flag;
              push_brk_c = 1'b1;
              state_n    = IDLE;
              ext_flag_n = 1'b0;
            end
          end
          default: begin
            state_n    = IDLE;
            ext_flag_n = 1'b0;
          end
        endcase
      end
    end else if (state == IDLE) begin
      to_cnt_n = '0;
    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      state_n    = IDLE;
      ext_flag_n = 1'b0;
      to_cnt_n   = '0;
    end else begin
      to_cnt_n = to_cnt + TO_W'(1);
    end
  end

  logic [7:0]        mem_code [DEPTH];
  logic              mem_ext  [DEPTH];
  logic              mem_brk  [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              pop_c, full_c, wr_c, ovf_c, bypass_c;
  logic [7:0]        head_code_c;
  logic              head_ext_c, head_brk_c;

  assign full_c   = (count == CNT_W'(DEPTH));
  assign pop_c    = rd_en && (count != '0);
  assign wr_c     = push_c && (!full_c || pop_c);
  assign ovf_c    = push_c && full_c && !pop_c;
  assign rd_ptr_n = pop_c ? rd_ptr + ADDR_W'(1) : rd_ptr;
  assign count_n  = count + CNT_W'(wr_c) - CNT_W'(pop_c);
  assign bypass_c = wr_c && (wr_ptr == rd_ptr_n);

  // Next head entry: freshly written data if it lands in the new head slot
  always_comb begin
    head_code_c = bypass_c ? push_code_c : mem_code[rd_ptr_n];
    head_ext_c  = bypass_c ? push_ext_c  : mem_ext[rd_ptr_n];
    head_brk_c  = bypass_c ? push_brk_c  : mem_brk[rd_ptr_n];
  end

  always_ff @(posedge clk_nexys) begin
    if (wr_c) begin
      mem_code[wr_ptr] <= push_code_c;
      mem_ext[wr_ptr]  <= push_ext_c;
      mem_brk[wr_ptr]  <= push_brk_c;
    end
  end

  // Pointers, count and registered head outputs; head holds while empty
  always_ff @(posedge clk_nexys or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_brk   <= 1'b0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      fifo_full <= (count_n == CNT_W'(DEPTH));
      overflow  <= ovf_c;
      if (wr_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (count_n != '0) begin
        evt_code <= head_code_c;
        evt_ext  <= head_ext_c;
        evt_brk  <= head_brk_c;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: a prefix-flag reference model
// predicts key events and FIFO status; a monitor checks them against the DUT.
module tb_ps2_scancode_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned T     = 40;

  logic       clk_nexys = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dato = 8'h00;
  logic       rd_en = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, fifo_full, overflow;
  logic [7:0] evt_code;

  ps2_scancode_decoder #(
    .DEPTH(DEPTH), .ADDR_W(2), .TIMEOUT_CYC(T), .TO_W(6)
  ) dut (
    .clk_nexys(clk_nexys), .reset(reset), .rx_done_tick(rx_done_tick),
    .dato(dato), .rd_en(rd_en), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk_nexys = ~clk_nexys;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_q [$];
  logic [2:0] status_q [$];

  bit m_ext = 0, m_brk = 0;
  int m_cyc = 0, m_last = 0, m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_disc(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  // Drive one clock's inputs and advance the reference model over that edge
  task automatic cycle(input bit tk, input logic [7:0] b, input bit rd);
    bit pop, ovf, ev;
    logic [9:0] e;
    @(posedge clk_nexys); #2;
    rx_done_tick = tk;
    dato = tk ? b : 8'($urandom);
    rd_en = rd;
    m_cyc++;
    ev = 0; e = '0; ovf = 0;
    if ((m_ext || m_brk) && (m_cyc - m_last > int'(T))) begin
      m_ext = 0; m_brk = 0;
    end
    if (tk) begin
      m_last = m_cyc;
      if (is_disc(b)) begin
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        ev = 1; e = {b, m_ext, m_brk};
        m_ext = 0; m_brk = 0;
      end
    end
    pop = rd && (m_cnt > 0);
    if (ev && m_cnt == int'(DEPTH) && !pop) ovf = 1;
    if (pop) m_cnt--;
    if (ev && !ovf) begin
      exp_q.push_back(e);
      m_cnt++;
    end
    status_q.push_back({m_cnt > 0, m_cnt == int'(DEPTH), ovf});
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: status after each edge, head entry on each pop
  always begin
    @(posedge clk_nexys); #1;
    if (status_q.size() > 0) begin
      logic [2:0] s;
      s = status_q.pop_front();
      chk("status{valid,full,ovf}", {29'd0, evt_valid, fifo_full, overflow}, {29'd0, s});
    end
    @(negedge clk_nexys);
    if (!reset && evt_valid && rd_en) begin
      if (exp_q.size() == 0) chk("unexpected_event", {22'd0, evt_code, evt_ext, evt_brk}, 32'hFFFF_FFFF);
      else chk("event{code,ext,brk}", {22'd0, evt_code, evt_ext, evt_brk}, {22'd0, exp_q.pop_front()});
    end
  end

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] disc [7];
    disc = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    r = $urandom_range(0, 99);
    if (r < 20) return 8'hE0;
    if (r < 40) return 8'hF0;
    if (r < 48) return disc[$urandom_range(0, 6)];
    return 8'($urandom_range(1, 255));
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, evt_valid}, 0);
    chk({tag, "_code"}, {24'd0, evt_code}, 0);
    chk({tag, "_ext"}, {31'd0, evt_ext}, 0);
    chk({tag, "_brk"}, {31'd0, evt_brk}, 0);
    chk({tag, "_full"}, {31'd0, fifo_full}, 0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 0);
  endtask

  initial begin
    #3;
    check_zero("reset");
    @(negedge clk_nexys);
    reset = 1'b0;

    send(8'h1C); cycle(0, 8'h00, 0); drain();
    send(8'hF0); send(8'h1C); drain();
    send(8'hE0); send(8'hF0); send(8'h74); drain();
    send(8'hE0); send(8'h75); drain();
    send(8'hE0); repeat (T) cycle(0, 8'h00, 0); send(8'h1C); drain();
    send(8'hE0); repeat (T - 1) cycle(0, 8'h00, 0); send(8'h6B); drain();
    send(8'hE0); send(8'hAA); send(8'h1C); drain();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); cycle(0, 8'h00, 0);
    send(8'h2C); cycle(0, 8'h00, 0); cycle(0, 8'h00, 0);
    cycle(1, 8'h3C, 1); cycle(0, 8'h00, 0); drain();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0)
        repeat ($urandom_range(T - 2, T + 2)) cycle(0, 8'h00, $urandom_range(0, 9) < 3);
      else
        cycle($urandom_range(0, 2) == 0, rand_byte(), $urandom_range(0, 9) < 3);
    end
    drain();

    send(8'h33); send(8'hE0); send(8'hF0); cycle(0, 8'h00, 0);
    @(posedge clk_nexys); #3;
    reset = 1'b1;
    exp_q.delete(); status_q.delete();
    m_ext = 0; m_brk = 0; m_cnt = 0;
    #1;
    check_zero("midreset");
    @(posedge clk_nexys); #3;
    reset = 1'b0;
    send(8'h1C); cycle(0, 8'h00, 0); drain();

    @(posedge clk_nexys); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
